base_wrr_arb: RTL and testbench

BASE_WRR_ARB -- requirements
Module: base_wrr_arb

---
 rtl/base_arb_pkg.sv | 8 +
 rtl/base_wrr_arb_if.sv | 17 +
 rtl/base_prienc_hp.sv | 17 +
 rtl/base_vlat_en.sv | 16 +
 rtl/base_wrr_arb.sv | 75 +++++++
 tb/tb_base_wrr_arb.sv | 141 ++++++++++++++
 6 files changed

// File: rtl/base_arb_pkg.sv
// base_arb_pkg: shared arbiter state encodings.
package base_arb_pkg;
    typedef enum logic [1:0] {
        ARB  = 2'd0,
        OWN  = 2'd1,
        LOCK = 2'd2
    } state_t;
endpackage

// File: rtl/base_wrr_arb_if.sv
// base_wrr_arb_if: request/grant handshake bundle between requesters and the arbiter.
interface base_wrr_arb_if #(
    parameter int ways = 4,
    parameter int wbits = 4
);
    logic [0:ways-1] i_v;
    logic [0:ways-1] i_h;
    logic [0:ways-1] i_r;
    logic [0:ways*wbits-1] i_wt;
    logic mode;
    logic o_r;
    logic o_v;
    logic [0:ways-1] o_s;
    logic o_h;
    modport slave (input i_v, i_h, i_wt, mode, o_r, output i_r, o_v, o_s, o_h);
    modport master (output i_v, i_h, i_wt, mode, o_r, input i_r, o_v, o_s, o_h);
endinterface

// File: rtl/base_prienc_hp.sv
// base_prienc_hp: one-hot grant of the lowest-indexed set request bit.
module base_prienc_hp #(
    parameter int n = 2
) (
    input  logic [0:n-1] req,
    output logic [0:n-1] gnt
);
    always_comb begin
        logic found;
        found = 1'b0;
        gnt = '0;
        for (int k = 0; k < n; k++) begin
            gnt[k] = req[k] & ~found;
            found = found | req[k];
        end
    end
endmodule

// File: rtl/base_vlat_en.sv
// base_vlat_en: enabled register with synchronous reset to a parameterised value.
module base_vlat_en #(
    parameter int w = 1,
    parameter logic [w-1:0] rv = '0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic [w-1:0] d,
    output logic [w-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset) q <= rv;
        else if (en) q <= d;
    end
endmodule

// File: rtl/base_wrr_arb.sv
// base_wrr_arb: zero-latency weighted round-robin / fixed-priority arbiter
// with per-way burst credit and locked transactions.
module base_wrr_arb
    import base_arb_pkg::*;
#(
    parameter int ways = 4,
    parameter int wbits = 4
) (
    input logic clk,
    input logic reset,
    base_wrr_arb_if.slave bus
);
    state_t st, st_d;
    logic [1:0] st_q;
    logic [0:ways-1] mask, mask_d, rmask, owner, sel, gnt, nm;
    logic [0:2*ways-1] dreq, dgnt;
    logic [wbits-1:0] cnt, cnt_d, cur_cnt, wt, cload;
    logic own_v, arb_path, act;

    assign st = state_t'(st_q);
    assign own_v = |(owner & bus.i_v);
    assign arb_path = (st == ARB) || (st == OWN && !own_v);
    // mask is the thermometer form of ptr; fixed priority searches only the unmasked copy
    assign rmask = bus.mode ? '0 : mask;
    assign dreq = {bus.i_v & rmask, bus.i_v};

    base_prienc_hp #(.n(2*ways)) u_enc (.req(dreq), .gnt(dgnt));

    assign gnt = dgnt[0:ways-1] | dgnt[ways:2*ways-1];
    assign sel = reset ? '0 : arb_path ? gnt : own_v ? owner : '0;
    // a locked owner that drops valid presents o_v without a selected way, so no beat is taken
    assign act = bus.o_r & |sel;
    assign bus.o_v = !reset & |bus.i_v;
    assign bus.o_s = sel;
    assign bus.o_h = |(sel & bus.i_h);
    assign bus.i_r = sel & {ways{bus.o_r}};

    always_comb begin
        logic run;
        run = 1'b0;
        wt = '0;
        nm = '0;
        for (int k = 0; k < ways; k++) begin
            wt = wt | (sel[k] ? bus.i_wt[k*wbits +: wbits] : '0);
            nm[k] = run;
            run = run | sel[k];
        end
        if (sel[ways-1]) nm = '1;
    end

    assign cload = (wt == '0) ? '0 : wt - 1'b1;

    always_comb begin
        st_d = st;
        cnt_d = cnt;
        mask_d = mask;
        cur_cnt = arb_path ? cload : cnt;
        if (bus.o_h) begin
            st_d = LOCK;
            cnt_d = cur_cnt;
        end else if (cur_cnt != '0) begin
            st_d = OWN;
            cnt_d = cur_cnt - 1'b1;
        end else begin
            st_d = ARB;
            cnt_d = '0;
            mask_d = bus.mode ? mask : nm;
        end
    end

    base_vlat_en #(.w(2)) u_st (.clk(clk), .reset(reset), .en(act), .d(st_d), .q(st_q));
    base_vlat_en #(.w(ways), .rv('1)) u_ptr (.clk(clk), .reset(reset), .en(act), .d(mask_d), .q(mask));
    base_vlat_en #(.w(wbits)) u_cnt (.clk(clk), .reset(reset), .en(act), .d(cnt_d), .q(cnt));
    base_vlat_en #(.w(ways)) u_own (.clk(clk), .reset(reset), .en(act), .d(sel), .q(owner));
endmodule

// File: tb/tb_base_wrr_arb.sv
// tb_base_wrr_arb: directed scenarios with an expectation queue checked each cycle.
module tb_base_wrr_arb;
    localparam int ways = 4;
    localparam int wbits = 4;

    typedef struct {
        string tag;
        logic [0:3] s;
        logic v;
        logic h;
        logic [0:3] r;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    base_wrr_arb_if #(.ways(ways), .wbits(wbits)) bus ();
    base_wrr_arb #(.ways(ways), .wbits(wbits)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s got %b want %b", tag, got, want);
        end
    endtask

    task automatic cyc(input string tag, input logic [0:3] v, input logic [0:3] h,
                       input logic orr, input logic [0:3] es, input logic eh);
        exp_t e;
        bus.i_v = v;
        bus.i_h = h;
        bus.o_r = orr;
        q.push_back('{tag, es, !reset && (|v), eh, es & {4{orr}}});
        @(negedge clk);
        e = q.pop_front();
        chk({e.tag, " o_s"}, bus.o_s, e.s);
        chk({e.tag, " i_r"}, bus.i_r, e.r);
        chk({e.tag, " o_v"}, {3'b000, bus.o_v}, {3'b000, e.v});
        chk({e.tag, " o_h"}, {3'b000, bus.o_h}, {3'b000, e.h});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc("reset", 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.i_v = '0;
        bus.i_h = '0;
        bus.o_r = 1'b0;
        bus.mode = 1'b0;
        bus.i_wt = {4'd1, 4'd1, 4'd1, 4'd1};
        @(posedge clk);
        #1;
        // plain round robin, unit weights
        do_reset();
        cyc("rr0", 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b0);
        cyc("rr1", 4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b0);
        cyc("rr2", 4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b0);
        cyc("rr3", 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0);
        cyc("rr4", 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b0);
        // weighted sequence 0,0,0,1,2,2,3 then repeat
        do_reset();
        bus.i_wt = {4'd3, 4'd1, 4'd2, 4'd1};
        cyc("w0a", 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b0);
        cyc("w0b", 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b0);
        cyc("w0c", 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b0);
        cyc("w1", 4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b0);
        cyc("w2a", 4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b0);
        cyc("w2b", 4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b0);
        cyc("w3", 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0);
        cyc("w0d", 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b0);
        // lock on way 1, owner drops out, then finishes
        do_reset();
        bus.i_wt = {4'd1, 4'd1, 4'd1, 4'd1};
        cyc("lk1", 4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1);
        cyc("lk2", 4'b0110, 4'b0100, 1'b1, 4'b0100, 1'b1);
        cyc("lk3", 4'b0110, 4'b0100, 1'b1, 4'b0100, 1'b1);
        cyc("gap1", 4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b0);
        cyc("gap2", 4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b0);
        cyc("lkend", 4'b0110, 4'b0000, 1'b1, 4'b0100, 1'b0);
        cyc("after", 4'b0110, 4'b0000, 1'b1, 4'b0010, 1'b0);
        cyc("wrap", 4'b1110, 4'b0000, 1'b1, 4'b1000, 1'b0);
        // fixed priority starves way 2 and leaves ptr alone
        do_reset();
        bus.mode = 1'b1;
        bus.i_wt = {4'd1, 4'd2, 4'd1, 4'd1};
        cyc("fp1", 4'b0110, 4'b0000, 1'b1, 4'b0100, 1'b0);
        cyc("fp2", 4'b0110, 4'b0000, 1'b1, 4'b0100, 1'b0);
        cyc("fp3", 4'b0110, 4'b0000, 1'b1, 4'b0100, 1'b0);
        cyc("fp4", 4'b0110, 4'b0000, 1'b1, 4'b0100, 1'b0);
        bus.mode = 1'b0;
        cyc("ptr0", 4'b1010, 4'b0000, 1'b1, 4'b1000, 1'b0);
        // mode change mid-turn waits for the next arbitration
        bus.i_wt = {4'd1, 4'd1, 4'd3, 4'd1};
        cyc("mc1", 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b0);
        bus.mode = 1'b1;
        cyc("mc2", 4'b1110, 4'b0000, 1'b1, 4'b0010, 1'b0);
        cyc("mc3", 4'b1110, 4'b0000, 1'b1, 4'b0010, 1'b0);
        cyc("mc4", 4'b1110, 4'b0000, 1'b1, 4'b1000, 1'b0);
        bus.mode = 1'b0;
        // reset during a lock on way 3
        do_reset();
        bus.i_wt = {4'd1, 4'd1, 4'd1, 4'd1};
        cyc("l3a", 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1);
        cyc("l3b", 4'b1111, 4'b0001, 1'b1, 4'b0001, 1'b1);
        reset = 1'b1;
        cyc("rlk1", 4'b1111, 4'b0001, 1'b1, 4'b0000, 1'b0);
        cyc("rlk2", 4'b1111, 4'b0001, 1'b1, 4'b0000, 1'b0);
        reset = 1'b0;
        cyc("rel", 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b0);
        // downstream stall mid-burst holds credit and ptr
        do_reset();
        bus.i_wt = {4'd3, 4'd1, 4'd1, 4'd1};
        cyc("st0", 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b0);
        for (int i = 0; i < 5; i++) cyc("stall", 4'b1111, 4'b0000, 1'b0, 4'b1000, 1'b0);
        cyc("st1", 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b0);
        cyc("st2", 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b0);
        cyc("st3", 4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b0);
        // zero weight acts as one; full weight gives 15 beats
        do_reset();
        bus.i_wt = {4'd0, 4'd15, 4'd0, 4'd0};
        cyc("z0", 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b0);
        for (int i = 0; i < 15; i++) cyc("full", 4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b0);
        cyc("z2", 4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b0);
        cyc("z3", 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0);
        cyc("idle", 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
